// File: rtl/subleq_io_pkg.sv
// Shared types and constants for the SUBLEQ operator-input path.
package subleq_io_pkg;

    localparam int DATA_W_DEF = 64;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Counter width able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int debounce_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/subleq_input_port_if.sv
// CPU-facing handshake and status bundle of the operator-input port.
interface subleq_input_port_if #(
    parameter int DATA_W = subleq_io_pkg::DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              pending;
    logic              overrun;

    modport master (output in_valid, in_data, pending, overrun, input in_ready);
    modport slave  (input in_valid, in_data, pending, overrun, output in_ready);
endinterface

// File: rtl/button_debouncer.sv
// Synchronise, debounce and rising-edge detect one button.
// Pulse appears SYNC_STAGES + DEBOUNCE_CYCLES cycles after a steady press; no backpressure.
module button_debouncer
    import subleq_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stable_q;
    logic                   stable_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= 1'b0;
            stable_d_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], btn};
            stable_d_q <= stable_q;
            // Any return to the stable level restarts the qualification window.
            if (sync_q[SYNC_STAGES-1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= ~stable_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pulse = stable_q & ~stable_d_q;

endmodule

// File: rtl/subleq_input_port.sv
// Captures a debounced switch word on submit and holds it on a valid/ready port until taken.
// SUBLEQ_INPUT_SIGN_EXTEND_EN selects sign- instead of zero-extension of the switch word.
module subleq_input_port
    import subleq_io_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW_W-1:0]      sw,
    input  logic                 btn_submit,
    input  logic                 btn_cancel,
    subleq_input_port_if.master  bus
);
    logic              submit_p;
    logic              cancel_p;
    logic [SW_W-1:0]   sw_sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] sw_ext;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overrun_q, overrun_d;

    button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit (
        .clk(clk), .rst(rst), .btn(btn_submit), .pulse(submit_p)
    );

    button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .clk(clk), .rst(rst), .btn(btn_cancel), .pulse(cancel_p)
    );

    // Switches are only sampled on a submit pulse, so they are synchronised but not debounced.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
        end else begin
            sw_sync_q[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
        end
    end

`ifdef SUBLEQ_INPUT_SIGN_EXTEND_EN
    assign sw_ext = {{(DATA_W-SW_W){sw_sync_q[SYNC_STAGES-1][SW_W-1]}}, sw_sync_q[SYNC_STAGES-1]};
`else
    assign sw_ext = {{(DATA_W-SW_W){1'b0}}, sw_sync_q[SYNC_STAGES-1]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (submit_p) begin
                    state_d = PENDING;
                    data_d  = sw_ext;
                    if (cancel_p) overrun_d = 1'b0;
                end else if (cancel_p) begin
                    overrun_d = 1'b0;
                end
            end
            PENDING: begin
                // A completing transfer outranks cancel; a same-cycle submit refills the slot.
                if (bus.in_ready) begin
                    if (submit_p) data_d = sw_ext;
                    else          state_d = IDLE;
                end else if (cancel_p) begin
                    state_d   = IDLE;
                    overrun_d = 1'b0;
                end else if (submit_p) begin
                    overrun_d = 1'b1;
                end
            end
        endcase
    end

    assign bus.in_valid = (state_q == PENDING);
    assign bus.pending  = (state_q == PENDING);
    assign bus.in_data  = data_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_subleq_input_port.sv
// Directed checks of subleq_input_port with a short debounce window.
module tb_subleq_input_port;
    localparam int DW   = 64;
    localparam int SWW  = 16;
    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + DEB + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [SWW-1:0] sw = '0;
    logic           btn_submit = 1'b0;
    logic           btn_cancel = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    subleq_input_port_if #(.DATA_W(DW)) bus ();

    subleq_input_port #(
        .DATA_W(DW), .SW_W(SWW), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .btn_submit(btn_submit), .btn_cancel(btn_cancel),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.submit_p) pulse_cnt <= pulse_cnt + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a button long enough for one pulse; optionally raise in_ready in the pulse cycle.
    task automatic press(input bit is_cancel, input bit rdy);
        if (is_cancel) btn_cancel = 1'b1;
        else           btn_submit = 1'b1;
        tick(LAT - 1);
        bus.in_ready = rdy;
        tick(1);
        bus.in_ready = 1'b0;
        btn_submit = 1'b0;
        btn_cancel = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_ready = 1'b0;
        tick(3);
        n_cmp++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", bus.in_valid); end
        n_cmp++; if (bus.in_data !== 64'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", bus.in_data); end
        n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got=%0b exp=0", bus.pending); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%0b exp=0", bus.overrun); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic_submit();
        int p0;
        p0 = pulse_cnt;
        sw = 16'h1234;
        btn_submit = 1'b1;
        tick(LAT - 1);
        n_cmp++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL early_valid got=%0b exp=0", bus.in_valid); end
        tick(1);
        n_cmp++; if (bus.in_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid got=%0b exp=1", bus.in_valid); end
        n_cmp++; if (bus.in_data !== 64'h1234) begin n_err++; $display("FAIL lat_data got=%h exp=1234", bus.in_data); end
        n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL lat_pending got=%0b exp=1", bus.pending); end
        bus.in_ready = 1'b1;
        tick(1);
        bus.in_ready = 1'b0;
        n_cmp++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL xfer_valid got=%0b exp=0", bus.in_valid); end
        n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL xfer_pending got=%0b exp=0", bus.pending); end
        tick(2);
        btn_submit = 1'b0;
        tick(10);
        n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL held_pulses got=%0d exp=1", pulse_cnt - p0); end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulse_cnt;
        btn_submit = 1'b1;
        tick(2);
        btn_submit = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            n_cmp++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid t=%0d got=%0b exp=0", i, bus.in_valid); end
        end
        n_cmp++; if (pulse_cnt !== p0) begin n_err++; $display("FAIL glitch_pulses got=%0d exp=0", pulse_cnt - p0); end
    endtask

    task automatic test_overrun();
        sw = 16'hAAAA;
        press(1'b0, 1'b0);
        n_cmp++; if (bus.in_data !== 64'hAAAA) begin n_err++; $display("FAIL ovr_first_data got=%h exp=aaaa", bus.in_data); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first_flag got=%0b exp=0", bus.overrun); end
        sw = 16'h5555;
        press(1'b0, 1'b0);
        n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got=%0b exp=1", bus.overrun); end
        n_cmp++; if (bus.in_data !== 64'hAAAA) begin n_err++; $display("FAIL ovr_data got=%h exp=aaaa", bus.in_data); end
        n_cmp++; if (bus.in_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got=%0b exp=1", bus.in_valid); end
        press(1'b1, 1'b0);
        n_cmp++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL cancel_valid got=%0b exp=0", bus.in_valid); end
        n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL cancel_pending got=%0b exp=0", bus.pending); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL cancel_overrun got=%0b exp=0", bus.overrun); end
    endtask

    task automatic test_ready_and_submit();
        sw = 16'h1111;
        press(1'b0, 1'b0);
        sw = 16'h00FF;
        btn_submit = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            tick(1);
            n_cmp++; if (bus.in_valid !== 1'b1) begin n_err++; $display("FAIL rs_hold_valid t=%0d got=%0b exp=1", i, bus.in_valid); end
        end
        bus.in_ready = 1'b1;
        tick(1);
        bus.in_ready = 1'b0;
        n_cmp++; if (bus.in_valid !== 1'b1) begin n_err++; $display("FAIL rs_valid got=%0b exp=1", bus.in_valid); end
        n_cmp++; if (bus.in_data !== 64'h00FF) begin n_err++; $display("FAIL rs_data got=%h exp=00ff", bus.in_data); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL rs_overrun got=%0b exp=0", bus.overrun); end
        btn_submit = 1'b0;
        tick(10);
        n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL rs_pending got=%0b exp=1", bus.pending); end
    endtask

    task automatic test_ready_and_cancel();
        sw = 16'h0F0F;
        press(1'b0, 1'b0);
        n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL rc_pre_overrun got=%0b exp=1", bus.overrun); end
        press(1'b1, 1'b1);
        n_cmp++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL rc_valid got=%0b exp=0", bus.in_valid); end
        n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL rc_overrun got=%0b exp=1", bus.overrun); end
        sw = 16'h7777;
        press(1'b0, 1'b0);
        press(1'b0, 1'b0);
        n_cmp++; if (bus.in_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got=%0b exp=1", bus.in_valid); end
        rst = 1'b1;
        tick(1);
        n_cmp++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", bus.in_valid); end
        n_cmp++; if (bus.in_data !== 64'h0) begin n_err++; $display("FAIL rst_data got=%h exp=0", bus.in_data); end
        n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL rst_pending got=%0b exp=0", bus.pending); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got=%0b exp=0", bus.overrun); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_extend();
        logic [DW-1:0] exp_data;
`ifdef SUBLEQ_INPUT_SIGN_EXTEND_EN
        exp_data = 64'hFFFF_FFFF_FFFF_8000;
`else
        exp_data = 64'h0000_0000_0000_8000;
`endif
        sw = 16'h8000;
        press(1'b0, 1'b0);
        n_cmp++; if (bus.in_data !== exp_data) begin n_err++; $display("FAIL ext_data got=%h exp=%h", bus.in_data, exp_data); end
        bus.in_ready = 1'b1;
        tick(1);
        bus.in_ready = 1'b0;
        n_cmp++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL ext_drain_valid got=%0b exp=0", bus.in_valid); end
    endtask

    initial begin
        bus.in_ready = 1'b0;
        test_reset();
        test_basic_submit();
        test_glitch();
        test_overrun();
        test_ready_and_submit();
        test_ready_and_cancel();
        test_extend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
